imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
Parameters (name, default, meaning):
REQ-001 ADDR_W, 10: instruction-memory word-address width.
REQ-002 DEPTH, 1024: maximum words loadable; DEPTH <= 2^ADDR_W.
Ports (name, direction, width, meaning):
REQ-003 clock  in  1: single clock. All state updates on the falling edge, matching the CPU pipeline.
REQ-004 reset_n  in  1: asynchronous, active-low reset.
REQ-005 start  in  1: request a new program load; sampled only in IDLE or DONE.
REQ-006 in_valid  in  1: byte-stream valid.
REQ-007 in_data  in  8: byte-stream data.
REQ-008 in_ready  out  1: loader can accept a byte.
REQ-009 mem_we  out  1: instruction-memory write strobe.
REQ-010 mem_addr  out  ADDR_W: word address, i.e. CPU PC>>1.
REQ-011 mem_wdata  out  16: instruction word.
REQ-012 cpu_hold  out  1: stall request to the CPU; high while a load is in progress.
REQ-013 done  out  1: load completed successfully.
REQ-014 err  out  1: load aborted or failed.

Function
REQ-015 Handshake: a byte transfers on a falling edge where in_valid and in_ready are both 1. in_ready is combinational from state only: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI and CSUM_LO.
REQ-016 Stream format: big-endian 16-bit word count N, then N big-endian words (high byte first), then the optional checksum (REQ-031).
REQ-017 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE.
REQ-018 Transitions:
- IDLE/DONE + start -> LEN_HI; clears done, err, the word counter and the sum.
- LEN_HI + xfer -> LEN_LO.
- LEN_LO + xfer -> DATA_HI if 0 < N <= DEPTH.
- LEN_LO + xfer with N == 0 -> CSUM_HI (checksum enabled) or DONE (disabled).
- LEN_LO + xfer with N > DEPTH -> IDLE, err = 1, no writes issued.
REQ-019 DATA_HI + xfer -> DATA_LO; the high byte is latched.
REQ-020 DATA_LO + xfer:
- mem_we = 1 for exactly one cycle, registered on that same edge.
- mem_wdata = {hi, lo}; mem_addr = word counter.
- Counter then increments.
- Next state: DATA_HI if the new count < N, else CSUM_HI (checksum enabled) or DONE (disabled).
REQ-021 Write latency: mem_we is high in the cycle immediately following the low-byte transfer. Words land at consecutive addresses 0..N-1 with no gaps and no wrap.
REQ-022 cpu_hold = 1 in every state except IDLE and DONE, including the cycle mem_we is high for the last word.
REQ-023 done = 1 while in DONE; err holds until the next start or reset.
REQ-024 start is ignored in all states other than IDLE and DONE.
REQ-025 in_valid while in_ready = 0 is ignored; no byte is consumed.
REQ-026 mem_addr and mem_wdata hold their last values when mem_we = 0.

Reset
REQ-027 reset_n low asynchronously forces:
- state = IDLE, in_ready = 0, mem_we = 0;
- mem_addr = 0, mem_wdata = 0;
- cpu_hold = 0, done = 0, err = 0;
- counters and sum = 0.
REQ-028 Reset mid-load abandons the transfer. Words already written remain in memory; no write is issued after reset asserts.
REQ-029 Outputs leave reset values no earlier than the first falling edge after reset_n deasserts.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN enables CSUM_HI/CSUM_LO.
REQ-031 Defined: after the data, a big-endian 16-bit checksum is received.
- Checksum = sum of all N words mod 2^16.
- Match -> DONE.
- Mismatch -> DONE with done = 0 and err = 1.
- Written words are not rolled back.
REQ-032 Undefined:
- CSUM states and the sum register are absent.
- Last data word -> DONE directly.
- err is raised only by an oversize N.

Verification
REQ-033 Stream 00 02 41 0F 42 07 -> writes addr0=0x410F, addr1=0x4207, each mem_we one cycle; cpu_hold high start->DONE; done = 1.
REQ-034 in_valid toggling 1/0 every cycle during REQ-033 -> identical writes; bytes consumed only when in_ready = 1.
REQ-035 Length 0x0401 (DEPTH = 1024) -> no mem_we, err = 1, state IDLE, cpu_hold = 0.
REQ-036 reset_n pulsed low after the first data word -> one write total (addr0), all outputs at reset values, subsequent start reloads from addr0.
REQ-037 With IMEM_LOADER_CHECKSUM_EN: REQ-033 stream + 83 16 -> done = 1. Same stream + 83 17 -> err = 1, done = 0.
REQ-038 Length 0x0000 -> DONE (checksum disabled) or accepts checksum 00 00 (enabled); no mem_we; start from DONE restarts cleanly.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length-prefixed big-endian words written to consecutive addresses.
// Optional trailing 16-bit checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE
   } state_t;

   localparam int CNT_W = ADDR_W + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CSUM_HI;
`else
   localparam state_t AFTER_DATA = DONE;
`endif

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [7:0]          hi_q, hi_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [15:0]         mem_wdata_q, mem_wdata_d;
   logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [15:0]         sum_q, sum_d;
`endif

   logic                xfer;
   logic [15:0]         len_word;
   logic [15:0]         data_word;
   logic [CNT_W-1:0]    cnt_inc;

   assign xfer      = in_valid & in_ready;
   assign len_word  = {len_q[15:8], in_data};
   assign data_word = {hi_q, in_data};
   assign cnt_inc   = cnt_q + 1'b1;

   // State register: everything moves on the falling edge to line up with the CPU pipeline.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         hi_q        <= '0;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         hi_q        <= hi_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      hi_d        = hi_q;
      cnt_d       = cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LEN_HI;
               err_d   = 1'b0;
               cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = in_data;
               state_d     = LEN_LO;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d = len_word;
               if (len_word == 16'd0) begin
                  state_d = AFTER_DATA;
               end else if (32'(len_word) > DEPTH) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else begin
                  state_d = DATA_HI;
               end
            end
         end
         DATA_HI: begin
            if (xfer) begin
               hi_d    = in_data;
               state_d = DATA_LO;
            end
         end
         DATA_LO: begin
            if (xfer) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = cnt_q[ADDR_W-1:0];
               mem_wdata_d = data_word;
               cnt_d       = cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d       = sum_q + data_word;
`endif
               state_d     = (32'(cnt_inc) < 32'(len_q)) ? DATA_HI : AFTER_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM_HI: begin
            if (xfer) begin
               hi_d    = in_data;
               state_d = CSUM_LO;
            end
         end
         CSUM_LO: begin
            if (xfer) begin
               err_d   = (data_word != sum_q);
               state_d = DONE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Hold stays up through the write strobe of the final word, even though state is already DONE.
   always_comb begin
      in_ready  = (state_q == LEN_HI)  || (state_q == LEN_LO)  ||
                  (state_q == DATA_HI) || (state_q == DATA_LO) ||
                  (state_q == CSUM_HI) || (state_q == CSUM_LO);
      cpu_hold  = ((state_q != IDLE) && (state_q != DONE)) || mem_we_q;
      done      = (state_q == DONE) && !err_q;
      err       = err_q;
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams length-prefixed programs and compares the write trace
// and status outputs against a queue-based model of the stream format.
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clock = ~clock;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]        stream[$];
   logic [15:0]       words[$];
   logic [ADDR_W-1:0] wr_addr[$];
   logic [15:0]       wr_data[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write trace: mem_we lasts one full cycle, so one rising-edge sample captures each write.
   always @(posedge clock) begin
      if (reset_n && mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic build_stream(input logic [15:0] len, input bit corrupt);
      logic [15:0] s;
      logic [15:0] c;
      s = 16'h0000;
      stream.delete();
      stream.push_back(len[15:8]);
      stream.push_back(len[7:0]);
      foreach (words[i]) begin
         stream.push_back(words[i][15:8]);
         stream.push_back(words[i][7:0]);
         s = s + words[i];
      end
      c = s + 16'(corrupt);
      if (CSUM) begin
         stream.push_back(c[15:8]);
         stream.push_back(c[7:0]);
      end
   endtask

   task automatic pulse_start();
      @(posedge clock);
      start = 1'b1;
      @(posedge clock);
      start = 1'b0;
   endtask

   // vmode < 0 toggles in_valid every cycle; otherwise it is the percent chance of valid.
   // Stray start pulses are thrown in; the loader must ignore them mid-load.
   task automatic drive_stream(input int max_bytes, input int vmode, input string tag);
      int idx;
      int cycles;
      bit v;
      bit hold_bad;
      idx = 0;
      cycles = 0;
      hold_bad = 1'b0;
      while (idx < max_bytes && cycles < 20000) begin
         @(posedge clock);
         v = (vmode < 0) ? (cycles % 2 == 0) : ($urandom_range(99) < vmode);
         in_valid = v;
         in_data  = v ? stream[idx] : 8'($urandom);
         start    = ($urandom_range(7) == 0);
         if (!cpu_hold) hold_bad = 1'b1;
         if (v && in_ready) idx++;
         cycles++;
      end
      @(posedge clock);
      in_valid = 1'b0;
      start    = 1'b0;
      check_val({tag, "_consumed"}, 64'(idx), 64'(max_bytes));
      check_val({tag, "_hold_during"}, 64'(hold_bad), 64'd0);
   endtask

   task automatic run_load(input int vmode, input bit corrupt, input string tag);
      int n;
      bit exp_err;
      n = words.size();
      exp_err = CSUM && corrupt;
      build_stream(16'(n), corrupt);
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      check_val({tag, "_start_status"}, {62'd0, done, err}, 64'd0);
      drive_stream(stream.size(), vmode, tag);
      check_val({tag, "_hold_last"}, 64'(cpu_hold), 64'((n > 0) && !CSUM));
      repeat (2) @(posedge clock);
      check_val({tag, "_done"}, 64'(done), 64'(!exp_err));
      check_val({tag, "_err"}, 64'(err), 64'(exp_err));
      check_val({tag, "_hold_end"}, 64'(cpu_hold), 64'd0);
      check_val({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(n));
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         if (n <= 16 || i == 0 || i == n - 1) begin
            check_val($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(i));
            check_val($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(words[i]));
         end else begin
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== words[i])
               check_val($sformatf("%s_word%0d", tag, i), {wr_addr[i], wr_data[i]}, {ADDR_W'(i), words[i]});
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val(tag, {57'd0, in_ready, mem_we, cpu_hold, done, err, 2'b00}, 64'd0);
      check_val({tag, "_addr"}, 64'(mem_addr), 64'd0);
      check_val({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   task automatic load_req33();
      words.delete();
      words.push_back(16'h410F);
      words.push_back(16'h4207);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      check_reset_outputs("reset");
      reset_n = 1'b1;

      load_req33();
      run_load(100, 1'b0, "basic");
      load_req33();
      run_load(-1, 1'b0, "toggle");
      if (CSUM) begin
         load_req33();
         run_load(100, 1'b1, "badsum");
      end

      // Oversize length aborts straight to IDLE with err set and no writes.
      words.delete();
      wr_addr.delete();
      stream.delete();
      stream.push_back(8'h04);
      stream.push_back(8'h01);
      pulse_start();
      drive_stream(2, 70, "oversize");
      repeat (2) @(posedge clock);
      check_val("oversize_status", {60'd0, in_ready, cpu_hold, done, err}, 64'h1);
      check_val("oversize_nwrites", 64'(wr_addr.size()), 64'd0);

      words.delete();
      run_load(100, 1'b0, "zero");
      run_load(60, 1'b0, "zero_again");

      // Reset right after the first word's write strobe.
      load_req33();
      build_stream(16'd2, 1'b0);
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      drive_stream(4, 100, "midreset");
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("midreset_rst");
      repeat (3) @(posedge clock);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      check_val("midreset_nwrites", 64'(wr_addr.size()), 64'd1);
      check_reset_outputs("midreset_after");
      load_req33();
      run_load(80, 1'b0, "reload");

      for (int t = 0; t < 6; t++) begin
         int n;
         n = $urandom_range(12, 1);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back(16'($urandom));
         run_load($urandom_range(100, 30), 1'($urandom_range(1)), $sformatf("rand%0d", t));
      end

      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back(16'($urandom));
      run_load(100, 1'b0, "full");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
